// File: rtl/imc_macro_seq_if.sv
// Request/response handshake bundle for the in-memory-compute sequencer.
// master drives requests and takes responses; slave is the sequencer side.
interface imc_macro_seq_if #(
  parameter int ROWS     = 16,
  parameter int COLS     = 16,
  parameter int ADC_BITS = 4
);
  localparam int AW = $clog2(ROWS);

  logic                     req_valid;
  logic                     req_ready;
  logic [1:0]               req_op;
  logic [AW-1:0]            req_addr;
  logic [COLS-1:0]          req_wdata;
  logic [ROWS-1:0]          req_act;
  logic [ROWS-1:0]          req_actb;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic                     rsp_err;
  logic [COLS-1:0]          rsp_rdata;
  logic [COLS*ADC_BITS-1:0] rsp_adc;

  modport master (
    output req_valid, req_op, req_addr, req_wdata,
    output req_act, req_actb, rsp_ready,
    input  req_ready, rsp_valid, rsp_err,
    input  rsp_rdata, rsp_adc
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata,
    input  req_act, req_actb, rsp_ready,
    output req_ready, rsp_valid, rsp_err,
    output rsp_rdata, rsp_adc
  );
endinterface

// File: rtl/imc_macro_seq.sv
// Sequenced SRAM in-memory-compute macro: write, sense-amp read, MAC + SAR ADC.
// IMC_SIGNED_MAC_EN enables signed MAC (act minus actb) with two's complement codes.
module imc_macro_seq #(
  parameter int ROWS       = 16,
  parameter int COLS       = 16,
  parameter int ADC_BITS   = 4,
  parameter int ADC_SHIFT  = 0,
  parameter int PRE_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  imc_macro_seq_if.slave  bus,
  output logic [ROWS-1:0] wwl,
  output logic [ROWS-1:0] rwl,
  output logic            pre_sram,
  output logic            saen,
  output logic            adc_en
);
  localparam int AW = $clog2(ROWS);
  localparam int SW = $clog2(ROWS + 1) + 1;
  localparam int BW = (ADC_BITS > 1) ? $clog2(ADC_BITS) : 1;
  localparam int PW = $clog2(PRE_CYCLES + 1);
`ifdef IMC_SIGNED_MAC_EN
  localparam int HALF = 1 << (ADC_BITS - 1);
`else
  localparam int HALF = 0;
`endif
  localparam logic [ADC_BITS-1:0] FLIP = ADC_BITS'(HALF);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_ACT, S_SENSE, S_CONV, S_DONE
  } state_t;

  state_t                     state;
  logic [1:0]                 op_q;
  logic [AW-1:0]              addr_q;
  logic [COLS-1:0]            wdata_q;
  logic [ROWS-1:0]            act_q;
  logic [PW-1:0]              pcnt;
  logic [BW-1:0]              bit_q;
  logic [COLS-1:0]            mem [ROWS];
  logic signed [SW-1:0]       sum_q [COLS];
  logic signed [SW-1:0]       sum_d [COLS];
  logic [ADC_BITS-1:0]        code_q [COLS];
  logic [ADC_BITS-1:0]        code_nx [COLS];
  logic [ADC_BITS-1:0]        trial [COLS];
  logic [COLS*ADC_BITS-1:0]   adc_nx;
  logic [ROWS-1:0]            row_sel;
  logic                       is_wr;
  logic                       is_rd;
  int                         acc;
`ifdef IMC_SIGNED_MAC_EN
  logic [ROWS-1:0]            actb_q;
  logic [ROWS-1:0]            rwlb;
`else
  logic                       unused_actb;
  assign unused_actb = ^bus.req_actb;
`endif

  assign row_sel = ROWS'(1) << addr_q;
  assign is_wr   = (op_q == 2'b00);
  assign is_rd   = (op_q == 2'b01);

  // Bitline sums from the driven wordlines, scaled before quantisation.
  always_comb begin
    acc = 0;
    for (int c = 0; c < COLS; c++) begin
      acc = 0;
      for (int r = 0; r < ROWS; r++) begin
        acc = acc + int'(rwl[r] & mem[r][c]);
`ifdef IMC_SIGNED_MAC_EN
        acc = acc - int'(rwlb[r] & mem[r][c]);
`endif
      end
      sum_d[c] = SW'(acc >>> ADC_SHIFT);
    end
  end

  // SAR step on an offset-binary target; over-range saturates naturally.
  always_comb begin
    adc_nx = '0;
    for (int c = 0; c < COLS; c++) begin
      trial[c] = code_q[c];
      trial[c][bit_q] = 1'b1;
      if (int'(trial[c]) <= int'(sum_q[c]) + HALF)
        code_nx[c] = trial[c];
      else
        code_nx[c] = code_q[c];
      adc_nx[c*ADC_BITS +: ADC_BITS] = code_nx[c] ^ FLIP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      op_q          <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      act_q         <= '0;
      pcnt          <= '0;
      bit_q         <= '0;
      wwl           <= '0;
      rwl           <= '0;
      pre_sram      <= 1'b0;
      saen          <= 1'b0;
      adc_en        <= 1'b0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_adc   <= '0;
      for (int r = 0; r < ROWS; r++)
        mem[r] <= '0;
      for (int c = 0; c < COLS; c++) begin
        sum_q[c]  <= '0;
        code_q[c] <= '0;
      end
`ifdef IMC_SIGNED_MAC_EN
      actb_q <= '0;
      rwlb   <= '0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            op_q          <= bus.req_op;
            addr_q        <= bus.req_addr;
            wdata_q       <= bus.req_wdata;
            act_q         <= bus.req_act;
`ifdef IMC_SIGNED_MAC_EN
            actb_q        <= bus.req_actb;
`endif
            bus.req_ready <= 1'b0;
            if (&bus.req_op) begin
              state         <= S_DONE;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
            end else begin
              state    <= S_PRE;
              pre_sram <= 1'b1;
              pcnt     <= '0;
            end
          end
        end
        S_PRE: begin
          if (pcnt == PW'(PRE_CYCLES - 1)) begin
            pre_sram <= 1'b0;
            state    <= S_ACT;
            unique case (1'b1)
              is_wr:   wwl <= row_sel;
              is_rd:   rwl <= row_sel;
              default: begin
                rwl <= act_q;
`ifdef IMC_SIGNED_MAC_EN
                rwlb <= actb_q;
`endif
              end
            endcase
          end else begin
            pcnt <= pcnt + 1'b1;
          end
        end
        S_ACT: begin
          wwl <= '0;
          unique case (1'b1)
            is_wr: begin
              mem[addr_q]   <= wdata_q;
              bus.rsp_valid <= 1'b1;
              state         <= S_DONE;
            end
            is_rd: begin
              rwl   <= '0;
              saen  <= 1'b1;
              state <= S_SENSE;
            end
            default: begin
              for (int c = 0; c < COLS; c++) begin
                sum_q[c]  <= sum_d[c];
                code_q[c] <= '0;
              end
              bit_q  <= BW'(ADC_BITS - 1);
              adc_en <= 1'b1;
              state  <= S_CONV;
            end
          endcase
        end
        S_SENSE: begin
          saen          <= 1'b0;
          bus.rsp_rdata <= mem[addr_q];
          bus.rsp_valid <= 1'b1;
          state         <= S_DONE;
        end
        S_CONV: begin
          for (int c = 0; c < COLS; c++)
            code_q[c] <= code_nx[c];
          if (bit_q == '0) begin
            adc_en        <= 1'b0;
            rwl           <= '0;
`ifdef IMC_SIGNED_MAC_EN
            rwlb          <= '0;
`endif
            bus.rsp_adc   <= adc_nx;
            bus.rsp_valid <= 1'b1;
            state         <= S_DONE;
          end else begin
            bit_q <= bit_q - 1'b1;
          end
        end
        S_DONE: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imc_macro_seq.sv
// Self-checking bench for imc_macro_seq against a behavioural array/MAC model.
// Honours IMC_SIGNED_MAC_EN in its reference model.
module tb_imc_macro_seq;
  localparam int ROWS = 16;
  localparam int COLS = 16;
  localparam int B    = 4;
  localparam int SH   = 0;
  localparam int PRE  = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imc_macro_seq_if #(.ROWS(ROWS), .COLS(COLS), .ADC_BITS(B)) bus ();
  logic [ROWS-1:0] wwl;
  logic [ROWS-1:0] rwl;
  logic            pre_sram;
  logic            saen;
  logic            adc_en;

  imc_macro_seq #(
    .ROWS(ROWS), .COLS(COLS), .ADC_BITS(B),
    .ADC_SHIFT(SH), .PRE_CYCLES(PRE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .wwl(wwl), .rwl(rwl), .pre_sram(pre_sram),
    .saen(saen), .adc_en(adc_en)
  );

  int ntests = 0;
  int nfail  = 0;
  logic [COLS-1:0]   ref_mem [ROWS];
  logic [COLS-1:0]   ref_rdata;
  logic [COLS*B-1:0] ref_adc;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [COLS*B-1:0] mac_model(
    logic [ROWS-1:0] act, logic [ROWS-1:0] actb);
    logic [COLS*B-1:0] res;
    int s, lo, hi;
    res = '0;
`ifdef IMC_SIGNED_MAC_EN
    lo = -(1 << (B - 1));
    hi = (1 << (B - 1)) - 1;
`else
    lo = 0;
    hi = (1 << B) - 1;
`endif
    for (int c = 0; c < COLS; c++) begin
      s = 0;
      for (int r = 0; r < ROWS; r++) begin
        if (act[r] && ref_mem[r][c]) s++;
`ifdef IMC_SIGNED_MAC_EN
        if (actb[r] && ref_mem[r][c]) s--;
`endif
      end
      s = s >>> SH;
      if (s > hi) s = hi;
      if (s < lo) s = lo;
      res[c*B +: B] = s[B-1:0];
    end
    return res;
  endfunction

  task automatic run(string tag, logic [1:0] op, int addr,
                     logic [COLS-1:0] wd, logic [ROWS-1:0] act,
                     logic [ROWS-1:0] actb, bit early, int hold);
    int lat, exp_lat, wwl_cyc, adc_cnt;
    logic [ROWS-1:0]   wwl_v, one;
    logic [COLS-1:0]   e_rd;
    logic [COLS*B-1:0] e_adc;
    logic              e_err;
    one   = 1;
    wwl_v = '0;
    e_rd  = ref_rdata;
    e_adc = ref_adc;
    e_err = 1'b0;
    case (op)
      2'b00: begin ref_mem[addr] = wd; exp_lat = PRE + 2; end
      2'b01: begin e_rd = ref_mem[addr]; exp_lat = PRE + 3; end
      2'b10: begin e_adc = mac_model(act, actb); exp_lat = PRE + B + 2; end
      default: begin e_err = 1'b1; exp_lat = 1; end
    endcase
    @(negedge clk);
    check({tag, " req_ready"}, 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = 4'(addr);
    bus.req_wdata = wd;
    bus.req_act   = act;
    bus.req_actb  = actb;
    bus.rsp_ready = early;
    @(posedge clk);
    lat = 0;
    wwl_cyc = -1;
    adc_cnt = 0;
    do begin
      @(negedge clk);
      lat++;
      bus.req_valid = 1'b0;
      if (wwl != '0) begin wwl_cyc = lat; wwl_v = wwl; end
      if (adc_en) adc_cnt++;
    end while (!bus.rsp_valid && lat < 40);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " rsp_err"}, 64'(bus.rsp_err), 64'(e_err));
    check({tag, " rsp_rdata"}, 64'(bus.rsp_rdata), 64'(e_rd));
    check({tag, " rsp_adc"}, bus.rsp_adc, e_adc);
    if (op == 2'b00) begin
      check({tag, " wwl cycle"}, 64'(wwl_cyc), 64'(PRE + 1));
      check({tag, " wwl"}, 64'(wwl_v), 64'(one << addr));
    end
    if (op == 2'b10)
      check({tag, " adc_en cycles"}, 64'(adc_cnt), 64'(B));
    ref_rdata = e_rd;
    ref_adc   = e_adc;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, " hold"}, {62'd0, bus.rsp_valid, bus.req_ready}, 64'b10);
    end
    if (!early) begin
      bus.rsp_ready = 1'b1;
      @(negedge clk);
    end else begin
      @(negedge clk);
    end
    bus.rsp_ready = 1'b0;
    check({tag, " release"}, {62'd0, bus.rsp_valid, bus.req_ready}, 64'b01);
  endtask

  initial begin
    int lat, seen;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_act   = '0;
    bus.req_actb  = '0;
    bus.rsp_ready = 1'b0;
    for (int r = 0; r < ROWS; r++) ref_mem[r] = '0;
    ref_rdata = '0;
    ref_adc   = '0;
    repeat (3) @(negedge clk);
    check("reset ctl", {58'd0, bus.req_ready, bus.rsp_valid, bus.rsp_err,
          pre_sram, saen, adc_en}, 64'b100000);
    check("reset wl", {32'd0, wwl, rwl}, 64'd0);
    check("reset data", {48'd0, bus.rsp_rdata} | bus.rsp_adc, 64'd0);
    rst_n = 1'b1;

    run("wr3", 2'b00, 3, 16'hA5C3, '0, '0, 1'b0, 0);
    run("rd3", 2'b01, 3, '0, '0, '0, 1'b0, 0);
    check("rd3 value", 64'(bus.rsp_rdata), 64'hA5C3);

    for (int r = 0; r < ROWS; r++)
      run("wrall", 2'b00, r, 16'hFFFF, '0, '0, r[0], 0);
    run("mac full", 2'b10, 0, '0, 16'hFFFF, '0, 1'b0, 0);
`ifndef IMC_SIGNED_MAC_EN
    check("mac full const", bus.rsp_adc, {16{4'hF}});
`endif

    run("wr0", 2'b00, 0, 16'h0001, '0, '0, 1'b0, 0);
    run("wr1", 2'b00, 1, 16'h0003, '0, '0, 1'b1, 0);
    run("wr2", 2'b00, 2, 16'h0007, '0, '0, 1'b0, 0);
    run("mac7", 2'b10, 0, '0, 16'h0007, '0, 1'b0, 0);
    check("mac7 const", bus.rsp_adc, 64'h123);

    run("mac zero", 2'b10, 0, '0, '0, '0, 1'b1, 0);

    for (int i = 0; i < 30; i++)
      run("rand", 2'($urandom_range(0, 2)), int'($urandom_range(0, ROWS - 1)),
          16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 0);

    run("illegal", 2'b11, 5, 16'h1234, 16'h00FF, '0, 1'b0, 5);
    run("illegal early", 2'b11, 0, '0, '0, '0, 1'b1, 0);

`ifdef IMC_SIGNED_MAC_EN
    for (int r = 0; r < ROWS; r++)
      run("wrall s", 2'b00, r, 16'hFFFF, '0, '0, 1'b0, 0);
    run("mac neg", 2'b10, 0, '0, '0, 16'hFFFF, 1'b0, 0);
    check("mac neg const", bus.rsp_adc, {16{4'h8}});
`endif

    run("wr9", 2'b00, 9, 16'h5A5A, '0, '0, 1'b0, 0);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b10;
    bus.req_act   = 16'hFFFF;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      lat++;
    end while (!adc_en && lat < 40);
    check("conv reached", 64'(adc_en), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("abort ctl", {58'd0, bus.req_ready, bus.rsp_valid, bus.rsp_err,
          pre_sram, saen, adc_en}, 64'b100000);
    check("abort wl", {32'd0, wwl, rwl}, 64'd0);
    check("abort data", {48'd0, bus.rsp_rdata} | bus.rsp_adc, 64'd0);
    for (int r = 0; r < ROWS; r++) ref_mem[r] = '0;
    ref_rdata = '0;
    ref_adc   = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    check("abort no rsp", 64'(seen), 64'd0);
    run("rd9 cleared", 2'b01, 9, '0, '0, '0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
